// File: rtl/dsm_ctrl_pkg.sv
// Shared types and default limits for the delta-sigma modulator controller.
// State encodings are exported so the bench and wrappers agree on them.
package dsm_ctrl_pkg;

  localparam int DSMC_T_BITS = 20;
  localparam logic [DSMC_T_BITS-1:0] DSMC_VIN_FS_HALF = 20'h40000;

  localparam int DSMC_HOLD_CYCLES  = 16;
  localparam int DSMC_RUN_LIMIT    = 64;
  localparam int DSMC_COOLDOWN     = 256;
  localparam int DSMC_MAX_RESTARTS = 3;
  localparam int DSMC_RC_BITS      = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RAMP    = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAULT   = 3'd4,
    ST_LOCKOUT = 3'd5
  } dsmc_state_e;

endpackage

// File: rtl/dsm_ctrl_if.sv
// Control/observation bundle between the controller and the modulator top.
// master = side that requests runs and returns pwm; slave = the controller.
interface dsm_ctrl_if #(
  parameter int T_BITS  = 20,
  parameter int RC_BITS = 2
);
  logic                      enable;
  logic signed [T_BITS-1:0]  vin_target;
  logic [1:0]                pwm;
  logic                      dsm_reset;
  logic signed [T_BITS-1:0]  vin_out;
  logic                      dith_en;
  logic [2:0]                state;
  logic                      fault;
  logic [RC_BITS-1:0]        restart_cnt;
  logic                      lockout;

  modport master (
    output enable, vin_target, pwm,
    input  dsm_reset, vin_out, dith_en, state, fault, restart_cnt, lockout
  );

  modport slave (
    input  enable, vin_target, pwm,
    output dsm_reset, vin_out, dith_en, state, fault, restart_cnt, lockout
  );
endinterface

// File: rtl/dsm_overload_mon.sv
// Quantizer overload monitor: flags long runs of one non-zero pwm code or the
// illegal code 2'b10; the flag is registered, one cycle after the sample.
module dsm_overload_mon #(
  parameter int RUN_LIMIT = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       arm,
  input  logic [1:0] pwm,
  output logic       overload
);
  localparam int CW = $clog2(RUN_LIMIT + 1);

  logic [1:0]    r_prev;
  logic [CW-1:0] r_cnt;
  logic          r_ovl;
  logic [CW-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = '0;
    if (pwm != 2'b00) begin
      if (pwm == r_prev)
        w_cnt_nxt = (r_cnt == CW'(RUN_LIMIT)) ? r_cnt : r_cnt + 1'b1;
      else
        w_cnt_nxt = CW'(1);
    end
  end

  // Counter keeps running while disarmed; only the flag is masked.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_prev <= 2'b00;
      r_cnt  <= '0;
      r_ovl  <= 1'b0;
    end else begin
      r_prev <= pwm;
      r_cnt  <= w_cnt_nxt;
      r_ovl  <= arm && ((pwm == 2'b10) || (w_cnt_nxt == CW'(RUN_LIMIT)));
    end
  end

  assign overload = r_ovl;
endmodule

// File: rtl/dsm_ctrl.sv
// Start-up, slew and overload-recovery controller for the delta-sigma
// modulator: holds it in reset, ramps vin slew-limited, restarts on overload.
module dsm_ctrl
  import dsm_ctrl_pkg::*;
#(
  parameter int               T_BITS       = DSMC_T_BITS,
  parameter int               HOLD_CYCLES  = DSMC_HOLD_CYCLES,
  parameter logic [T_BITS-1:0] RAMP_STEP   = T_BITS'('h00400),
  parameter int               RUN_LIMIT    = DSMC_RUN_LIMIT,
  parameter int               COOLDOWN     = DSMC_COOLDOWN,
  parameter int               MAX_RESTARTS = DSMC_MAX_RESTARTS,
  parameter int               RC_BITS      = DSMC_RC_BITS
) (
  input  logic        clock,
  input  logic        reset,
  dsm_ctrl_if.slave   bus
);
  localparam int TMR_MAX = (HOLD_CYCLES > COOLDOWN) ? HOLD_CYCLES : COOLDOWN;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] COOL_LOAD = TMR_W'(COOLDOWN - 1);

  typedef struct packed {
    logic                     done;
    logic signed [T_BITS-1:0] val;
  } slew_t;

  dsmc_state_e              r_state;
  logic                     r_dsm_reset;
  logic signed [T_BITS-1:0] r_vin;
  logic                     r_dith;
  logic                     r_fault;
  logic [RC_BITS-1:0]       r_rc;
  logic                     r_lock;
  logic [TMR_W-1:0]         r_tmr;

  slew_t                    w_slew;
  logic                     w_ovl;
  logic                     w_arm;
  logic [RC_BITS-1:0]       w_rc_inc;

  // Delta is formed one bit wider so target/current extremes cannot overflow.
  function automatic slew_t slew_step(input logic signed [T_BITS-1:0] tgt,
                                      input logic signed [T_BITS-1:0] cur);
    logic signed [T_BITS:0] w_delta;
    logic signed [T_BITS:0] w_step;
    slew_t                  w_res;
    w_delta = $signed({tgt[T_BITS-1], tgt}) - $signed({cur[T_BITS-1], cur});
    w_step  = $signed({1'b0, RAMP_STEP});
    if ((w_delta <= w_step) && (w_delta >= -w_step)) begin
      w_res.done = 1'b1;
      w_res.val  = tgt;
    end else if (w_delta[T_BITS]) begin
      w_res.done = 1'b0;
      w_res.val  = cur - $signed(RAMP_STEP);
    end else begin
      w_res.done = 1'b0;
      w_res.val  = cur + $signed(RAMP_STEP);
    end
    return w_res;
  endfunction

  assign w_slew   = slew_step(bus.vin_target, r_vin);
  assign w_arm    = (r_state == ST_RUN);
  assign w_rc_inc = r_rc + 1'b1;

  dsm_overload_mon #(.RUN_LIMIT(RUN_LIMIT)) u_mon (
    .clock    (clock),
    .reset    (reset),
    .clear    (r_dsm_reset),
    .arm      (w_arm),
    .pwm      (bus.pwm),
    .overload (w_ovl)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_dsm_reset <= 1'b1;
      r_vin       <= '0;
      r_dith      <= 1'b0;
      r_fault     <= 1'b0;
      r_rc        <= '0;
      r_lock      <= 1'b0;
      r_tmr       <= '0;
    end else begin
      r_fault <= 1'b0;
      // Dropping enable wins over everything, including a pending overload.
      if (!bus.enable) begin
        r_state     <= ST_IDLE;
        r_dsm_reset <= 1'b1;
        r_vin       <= '0;
        r_dith      <= 1'b0;
        r_rc        <= '0;
        r_lock      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state     <= ST_HOLD;
            r_tmr       <= HOLD_LOAD;
            r_dsm_reset <= 1'b1;
            r_vin       <= '0;
            r_dith      <= 1'b0;
            r_rc        <= '0;
            r_lock      <= 1'b0;
          end
          ST_HOLD: begin
            if (r_tmr == '0) begin
              r_state     <= ST_RAMP;
              r_dsm_reset <= 1'b0;
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
          ST_RAMP: begin
            r_vin <= w_slew.val;
            if (w_slew.done) begin
              r_state <= ST_RUN;
              r_dith  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_ovl) begin
              r_fault     <= 1'b1;
              r_rc        <= w_rc_inc;
              r_dsm_reset <= 1'b1;
              r_vin       <= '0;
              r_dith      <= 1'b0;
              if (w_rc_inc < RC_BITS'(MAX_RESTARTS)) begin
                r_state <= ST_FAULT;
                r_tmr   <= COOL_LOAD;
              end else begin
                r_state <= ST_LOCKOUT;
                r_lock  <= 1'b1;
              end
            end else begin
              r_vin <= w_slew.val;
            end
          end
          ST_FAULT: begin
            // Cooldown doubles as the reset hold, so restart goes straight to RAMP.
            if (r_tmr == '0) begin
              r_state     <= ST_RAMP;
              r_dsm_reset <= 1'b0;
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
          ST_LOCKOUT: begin
            r_dsm_reset <= 1'b1;
            r_vin       <= '0;
            r_dith      <= 1'b0;
            r_lock      <= 1'b1;
          end
          default: begin
            r_state     <= ST_IDLE;
            r_dsm_reset <= 1'b1;
            r_vin       <= '0;
            r_dith      <= 1'b0;
            r_rc        <= '0;
            r_lock      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dsm_reset   = r_dsm_reset;
  assign bus.vin_out     = r_vin;
  assign bus.dith_en     = r_dith;
  assign bus.state       = r_state;
  assign bus.fault       = r_fault;
  assign bus.restart_cnt = r_rc;
  assign bus.lockout     = r_lock;
endmodule

// File: tb/tb_dsm_ctrl.sv
// Directed bench for dsm_ctrl: vector table for start-up and slew, plus
// hand-written sequences for overload, cooldown, lockout and enable/reset priority.
module tb_dsm_ctrl;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dsm_ctrl_if #(.T_BITS(20), .RC_BITS(2)) bus ();

  dsm_ctrl #(
    .T_BITS(20), .HOLD_CYCLES(16), .RAMP_STEP(20'h00400), .RUN_LIMIT(64),
    .COOLDOWN(256), .MAX_RESTARTS(3), .RC_BITS(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        en;
    logic [19:0] tgt;
    logic [1:0]  pwm;
    logic [2:0]  st;
    logic        rst;
    logic [19:0] vin;
    logic        dith;
    logic        flt;
    logic [1:0]  rc;
    logic        lock;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic en, input logic [19:0] tgt, input logic [1:0] pwm,
                              input logic [2:0] st, input logic rst, input logic [19:0] vin,
                              input logic dith);
    vec_t v;
    v.en = en; v.tgt = tgt; v.pwm = pwm; v.st = st; v.rst = rst; v.vin = vin;
    v.dith = dith; v.flt = 1'b0; v.rc = 2'd0; v.lock = 1'b0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  // Packed as {state, dsm_reset, vin_out, dith_en, fault, restart_cnt, lockout}.
  task automatic chk_all(input string nm, input logic [2:0] st, input logic rst,
                         input logic [19:0] vin, input logic dith, input logic flt,
                         input logic [1:0] rc, input logic lock);
    chk(nm, {3'b0, bus.state, bus.dsm_reset, bus.vin_out, bus.dith_en, bus.fault,
             bus.restart_cnt, bus.lockout},
        {3'b0, st, rst, vin, dith, flt, rc, lock});
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int n;
    n = 0;
    while (bus.state !== s && n < budget) begin
      tick();
      n++;
    end
    chk(nm, {29'b0, bus.state}, {29'b0, s});
  endtask

  task automatic inject10();
    bus.pwm = 2'b10;
    tick();
    bus.pwm = 2'b00;
    tick();
  endtask

  initial begin
    int nf;

    // Start-up: 16 HOLD cycles, then ramp 0x400 per edge to 0x1000.
    vt.push_back(mk(1'b1, 20'h01000, 2'b00, 3'd1, 1'b1, 20'h00000, 1'b0));
    for (int i = 0; i < 15; i++)
      vt.push_back(mk(1'b1, 20'h01000, 2'b00, 3'd1, 1'b1, 20'h00000, 1'b0));
    vt.push_back(mk(1'b1, 20'h01000, 2'b00, 3'd2, 1'b0, 20'h00000, 1'b0));
    vt.push_back(mk(1'b1, 20'h01000, 2'b00, 3'd2, 1'b0, 20'h00400, 1'b0));
    vt.push_back(mk(1'b1, 20'h01000, 2'b00, 3'd2, 1'b0, 20'h00800, 1'b0));
    vt.push_back(mk(1'b1, 20'h01000, 2'b00, 3'd2, 1'b0, 20'h00C00, 1'b0));
    vt.push_back(mk(1'b1, 20'h01000, 2'b00, 3'd3, 1'b0, 20'h01000, 1'b1));
    // Target step to -0x1000 while running: slew-limited descent through zero.
    vt.push_back(mk(1'b1, 20'hFF000, 2'b00, 3'd3, 1'b0, 20'h00C00, 1'b1));
    vt.push_back(mk(1'b1, 20'hFF000, 2'b00, 3'd3, 1'b0, 20'h00800, 1'b1));
    vt.push_back(mk(1'b1, 20'hFF000, 2'b00, 3'd3, 1'b0, 20'h00400, 1'b1));
    vt.push_back(mk(1'b1, 20'hFF000, 2'b00, 3'd3, 1'b0, 20'h00000, 1'b1));
    vt.push_back(mk(1'b1, 20'hFF000, 2'b00, 3'd3, 1'b0, 20'hFFC00, 1'b1));
    vt.push_back(mk(1'b1, 20'hFF000, 2'b00, 3'd3, 1'b0, 20'hFF800, 1'b1));
    vt.push_back(mk(1'b1, 20'hFF000, 2'b00, 3'd3, 1'b0, 20'hFF400, 1'b1));
    vt.push_back(mk(1'b1, 20'hFF000, 2'b00, 3'd3, 1'b0, 20'hFF000, 1'b1));
    vt.push_back(mk(1'b1, 20'hFF000, 2'b00, 3'd3, 1'b0, 20'hFF000, 1'b1));

    reset = 1'b1;
    bus.enable = 1'b0;
    bus.vin_target = '0;
    bus.pwm = 2'b00;
    tick();
    tick();
    chk_all("reset_values", 3'd0, 1'b1, 20'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    tick();
    chk_all("idle_disabled", 3'd0, 1'b1, 20'h0, 1'b0, 1'b0, 2'd0, 1'b0);

    foreach (vt[i]) begin
      bus.enable = vt[i].en;
      bus.vin_target = vt[i].tgt;
      bus.pwm = vt[i].pwm;
      tick();
      chk_all($sformatf("vec%0d", i), vt[i].st, vt[i].rst, vt[i].vin, vt[i].dith,
              vt[i].flt, vt[i].rc, vt[i].lock);
    end

    // Runs of 63, a zero, then 63 again must not trip the monitor.
    nf = 0;
    bus.pwm = 2'b01;
    for (int i = 0; i < 63; i++) begin tick(); if (bus.fault) nf++; end
    bus.pwm = 2'b00;
    tick(); if (bus.fault) nf++;
    bus.pwm = 2'b01;
    for (int i = 0; i < 63; i++) begin tick(); if (bus.fault) nf++; end
    bus.pwm = 2'b00;
    for (int i = 0; i < 3; i++) begin tick(); if (bus.fault) nf++; end
    chk("no_fault_63_gap_63", nf, 0);
    chk_all("run_after_63", 3'd3, 1'b0, 20'hFF000, 1'b1, 1'b0, 2'd0, 1'b0);

    nf = 0;
    for (int i = 0; i < 1000; i++) begin
      bus.pwm = (i % 2 == 0) ? 2'b01 : 2'b11;
      tick();
      if (bus.fault) nf++;
    end
    bus.pwm = 2'b00;
    tick(); if (bus.fault) nf++;
    chk("no_fault_alternating", nf, 0);

    // 64 identical codes: fault appears on the edge after the 64th sample.
    bus.pwm = 2'b01;
    for (int i = 0; i < 64; i++) tick();
    chk_all("pre_fault", 3'd3, 1'b0, 20'hFF000, 1'b1, 1'b0, 2'd0, 1'b0);
    bus.pwm = 2'b00;
    tick();
    chk_all("fault_entry", 3'd4, 1'b1, 20'h0, 1'b0, 1'b1, 2'd1, 1'b0);
    tick();
    chk_all("fault_pulse_end", 3'd4, 1'b1, 20'h0, 1'b0, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 254; i++) tick();
    chk("fault_hold_255", {29'b0, bus.state}, 32'd4);
    tick();
    chk_all("fault_to_ramp", 3'd2, 1'b0, 20'h0, 1'b0, 1'b0, 2'd1, 1'b0);
    tick();
    chk_all("reramp_first", 3'd2, 1'b0, 20'hFFC00, 1'b0, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk_all("rerun", 3'd3, 1'b0, 20'hFF000, 1'b1, 1'b0, 2'd1, 1'b0);

    // Illegal code trips immediately; third overload locks out.
    inject10();
    chk_all("fault2_illegal", 3'd4, 1'b1, 20'h0, 1'b0, 1'b1, 2'd2, 1'b0);
    wait_state(3'd3, 400, "rerun2");
    inject10();
    chk_all("lockout_entry", 3'd5, 1'b1, 20'h0, 1'b0, 1'b1, 2'd3, 1'b1);
    tick();
    chk_all("lockout_hold", 3'd5, 1'b1, 20'h0, 1'b0, 1'b0, 2'd3, 1'b1);
    bus.enable = 1'b0;
    tick();
    chk_all("lockout_exit", 3'd0, 1'b1, 20'h0, 1'b0, 1'b0, 2'd0, 1'b0);

    // Enable drop on the edge where the overload would be acted on.
    bus.enable = 1'b1;
    wait_state(3'd3, 100, "run3");
    bus.pwm = 2'b01;
    for (int i = 0; i < 64; i++) tick();
    bus.pwm = 2'b00;
    bus.enable = 1'b0;
    tick();
    chk_all("en_drop_priority", 3'd0, 1'b1, 20'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    chk("no_late_fault", {31'b0, bus.fault}, 32'd0);

    // Synchronous reset in the middle of a ramp.
    bus.enable = 1'b1;
    bus.vin_target = 20'h01000;
    wait_state(3'd2, 40, "ramp4");
    tick();
    chk_all("mid_ramp", 3'd2, 1'b0, 20'h00400, 1'b0, 1'b0, 2'd0, 1'b0);
    reset = 1'b1;
    tick();
    chk_all("reset_mid_ramp", 3'd0, 1'b1, 20'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    bus.enable = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dsm_ctrl.md
Name: dsm_ctrl

Overview:
- Start-up, slew and stability controller for the second-order delta-sigma modulator top level (DSM_top).
- Drives the modulator's reset, the input sample (vin) and the dither enable.
- Watches the 2-bit pwm output for quantizer overload: long runs of one non-zero code, or the illegal code 2'b10.
- On overload, resets and re-ramps the modulator a bounded number of times, then locks out.

Parameters:
- T_BITS, 20: datapath width; matches `T_BITS.
- HOLD_CYCLES, 16: cycles dsm_reset is held before each fresh start.
- RAMP_STEP, 20'h00400: maximum per-cycle change of vin_out (slew limit).
- RUN_LIMIT, 64: consecutive identical non-zero pwm codes that count as overload.
- COOLDOWN, 256: cycles held in FAULT before re-ramp.
- MAX_RESTARTS, 3: overloads tolerated before LOCKOUT.
- RC_BITS, 2: width of restart_cnt; must satisfy 2^RC_BITS > MAX_RESTARTS.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run request; level-sensitive
- vin_target  in  T_BITS  signed two's-complement target input sample
- pwm  in  2  DSM_top.pwm (00 zero, 01 +FS/2, 11 -FS/2, 10 illegal)
- dsm_reset  out  1  ORed into the DSM_top reset
- vin_out  out  T_BITS  slew-limited signed sample driven to DSM_top.vin
- dith_en  out  1  gates dith_i to zero when low
- state  out  3  current FSM state encoding
- fault  out  1  one-cycle pulse on each overload detection
- restart_cnt  out  RC_BITS  overloads since last IDLE
- lockout  out  1  high while in LOCKOUT

Behaviour:
- One clock. Reset is synchronous and active-high; ports are named clock and reset.
- All outputs are registered.
- Reset values: state=IDLE(0), dsm_reset=1, vin_out=0, dith_en=0, fault=0, restart_cnt=0, lockout=0.
- States: IDLE=0, HOLD=1, RAMP=2, RUN=3, FAULT=4, LOCKOUT=5. Codes 6 and 7 recover to IDLE.
- Global rule: enable=0 in any state sends the FSM to IDLE on the next edge. This has priority over overload; no fault pulse and no count increment occur on that edge.
- IDLE:
  - dsm_reset=1, vin_out=0, restart_cnt cleared.
  - enable=1 → HOLD, with the hold counter loaded to HOLD_CYCLES-1.
- HOLD:
  - dsm_reset=1 for exactly HOLD_CYCLES cycles.
  - At counter 0 → RAMP; dsm_reset falls on the same edge.
- RAMP:
  - Slew step each cycle: delta = vin_target - vin_out, computed in T_BITS+1 signed (no overflow).
  - If |delta| <= RAMP_STEP then vin_out <= vin_target and → RUN; else vin_out += sign(delta)*RAMP_STEP.
  - The overload monitor is masked.
- RUN:
  - The same slew step continues, so target changes stay slew-limited. dith_en=1.
  - The monitor is armed.
  - Overload → fault pulse and restart_cnt+1. If the new count < MAX_RESTARTS → FAULT; else → LOCKOUT.
- FAULT:
  - dsm_reset=1, vin_out=0, dith_en=0, cooldown counter loaded to COOLDOWN-1.
  - At 0 → RAMP. The cooldown covers the hold, so HOLD is skipped.
- LOCKOUT:
  - dsm_reset=1, vin_out=0, lockout=1.
  - Leaves only via enable=0 (→ IDLE, which clears the count).
- Monitor:
  - Keeps prev_pwm and a run counter saturating at RUN_LIMIT.
  - The counter increments when pwm==prev_pwm and pwm!=00; otherwise it reloads to 1 (non-zero pwm) or 0 (pwm 00).
  - Overload when the count reaches RUN_LIMIT, or when pwm==10 (immediate).
  - The counter is cleared whenever dsm_reset=1.
  - Detection is one cycle after the offending pwm sample.
- dith_en=0 in every state except RUN.
- vin_out changes in no state other than RAMP and RUN, except for the forced zero in IDLE, FAULT and LOCKOUT.

Decomposition:
- State encodings (`DSMC_IDLE..`DSMC_LOCKOUT) and default limits go in parameters.vh alongside `T_BITS, `VIN_FS_HALF.
- One sub-module, dsm_overload_mon:
  - inputs: clock, reset, clear, arm, pwm
  - output: overload
  - contains the prev_pwm/run-length counter.
- The FSM, counters and slew limiter live in dsm_ctrl.

Test Plan:
- Reset, then enable=1 with vin_target=20'h01000 → dsm_reset=1 for 16 cycles after HOLD entry. RAMP gives vin_out 0x400, 0x800, 0xC00, 0x1000. RUN is entered with dith_en=1 on the 0x1000 edge.
- In RUN, vin_target steps 20'h01000→20'hFF000 (-0x1000) → vin_out falls by 0x400 per cycle through 0xC00…0xFFC00, then equals 0xFF000. No fault.
- In RUN, pwm held at 01 for 64 cycles → fault pulses once, restart_cnt=1, state=FAULT, dsm_reset=1. After 256 cycles state=RAMP, vin_out restarts from 0.
- Three overloads via pwm=10 injected in RUN → third gives state=LOCKOUT, lockout=1, restart_cnt=3. enable=0 → IDLE, restart_cnt=0.
- pwm alternating 01/11 for 1000 cycles in RUN → no fault. pwm 01 for 63 cycles, then one 00, then 01 for 63 cycles → no fault.
- enable dropped on the same edge as a 64th repeated pwm → state=IDLE, fault=0, restart_cnt unchanged/cleared. Reset asserted mid-RAMP → all outputs at reset values on the next edge.
